despachante_troco: RTL
======================

# despachante_troco

Change-dispensing controller for the vending machine. On a start pulse it latches the change amount (`valor_troco`) and a snapshot of the wallet coin inventory (`moedas_carteira`). It then sequences the coin ejector one coin at a time, using greedy largest-denomination-first selection with a request/ready handshake. It sits between `vm`, which computes change and owns the wallet, and the physical coin ejector; the wallet decrements on each accepted eject.

## Interface
- `TIMEOUT_CICLOS`, 15: ejector wait limit in cycles; used only with the watchdog macro.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start pulse; sampled only in OCIOSO.
- `valor_troco`  in  8  change amount in cents, latched on accepted `iniciar`.
- `moedas_carteira`  in  24  six 4-bit coin counts; slot k = bits [4k+3:4k].
- `ejetor_pronto`  in  1  ejector accepts the current coin.
- `ejetar`  out  1  eject request.
- `moeda_sel`  out  3  slot index of the requested coin, 0–5.
- `ocupado`  out  1  high in every state except OCIOSO.
- `concluido`  out  1  one-cycle completion pulse.
- `erro`  out  1  exact change impossible, or timeout; valid while `concluido` is high.
- `falta`  out  8  undispensed remainder; valid while `concluido` is high.

## Operation
- Denominations by slot 0..5: 1, 5, 10, 25, 50, 100 cents.
- Internal registers:
  - `resto` (8 bit): remaining amount.
  - `cont[0..5]` (4 bit each): local coin counts.
  - `slot` (3 bit): selected slot.
- States:
  - **OCIOSO**: on `iniciar`=1, load `resto`←`valor_troco` and `cont`←`moedas_carteira`, then go to BUSCA.
  - **BUSCA**:
    - If `resto`=0, go to FIM with `erro`=0.
    - Otherwise pick the highest slot with denomination ≤ `resto` and `cont`>0, register `moeda_sel`, set `ejetar`=1, and go to EJETA.
    - If no slot qualifies, go to FIM with `erro`=1.
  - **EJETA**:
    - Hold `ejetar` and `moeda_sel` stable.
    - On `ejetor_pronto`=1 at an edge: `resto`−=denomination, `cont[slot]`−=1, `ejetar`←0, go to BUSCA.
  - **FIM**: `concluido`=1 and `falta`=`resto`, then go to OCIOSO.
- `iniciar` outside OCIOSO is ignored. No queuing.
- Inputs are not re-sampled after the load. Wallet changes during operation are not seen until the next `iniciar`.
- Arithmetic:
  - Subtraction cannot underflow, because selection guarantees denomination ≤ `resto`.
  - `cont` never decrements below 0.
- Greedy non-optimality is accepted behaviour; there is no backtracking.
- Reset, including mid-operation, forces OCIOSO immediately. All outputs go to 0 asynchronously, and `ejetar` drops without completing the handshake.

## Timing
- All outputs are registered. Reset values: `ejetar`=0, `moeda_sel`=0, `ocupado`=0, `concluido`=0, `erro`=0, `falta`=0.
- `iniciar` is sampled at edge E0.
  - `ocupado`=1 after E0.
  - `ejetar`=1 after E1, at the earliest.
- With `ejetor_pronto` tied high, each coin costs 2 cycles (BUSCA + EJETA).
- `ejetor_pronto` while `ejetar`=0 is ignored. The handshake completes only when both are high at the same edge.
- `concluido`, `erro` and `falta` are valid for exactly one cycle. `ocupado` drops on the edge that ends FIM.
- Zero change: `concluido` is high after E1, with no eject.

## Configuration
- `EJETOR_TIMEOUT_EN` defined:
  - A 4-bit watchdog counts cycles spent in EJETA and clears on entry.
  - When it reaches `TIMEOUT_CICLOS` without `ejetor_pronto`, `ejetar` drops and the FSM goes to FIM with `erro`=1 and `falta`=`resto`, where `resto` still includes the unaccepted coin.
- Undefined: EJETA waits indefinitely, and the counter logic is absent.

## Structure
- Shared package `vm_pkg`:
  - denomination constant array
  - `N_SLOTS`=6
  - `LARG_CONT`=4
  - FSM state enum (OCIOSO, BUSCA, EJETA, FIM)
- One sub-module, `seletor_moeda`: a combinational priority picker. Inputs are `resto` and `cont[0..5]`; outputs are `valido` and `slot`.

## Test plan
- **Normal change**: `valor_troco`=40, counts slot3=1, slot2=2, slot1=1, `ejetor_pronto`=1 → ejects slots 3, 2, 1 (25+10+5); `concluido` with `erro`=0, `falta`=0.
- **Exact change impossible**: `valor_troco`=30, only slot3=1 and slot0=3 → ejects 25, 1, 1, 1; then `erro`=1, `falta`=2.
- **Zero change**: `valor_troco`=0 → no `ejetar`; `concluido` one cycle after E1 with `erro`=0.
- **Slow ejector**: `ejetor_pronto` delayed 5 cycles per coin → `ejetar`/`moeda_sel` stable for the whole wait; each coin consumed once; `iniciar` pulsed mid-run is ignored.
- **Reset mid-operation**: `reset_n`=0 during EJETA → `ejetar`, `ocupado` and all other outputs 0 immediately; a new `iniciar` runs normally.
- **Watchdog** (`EJETOR_TIMEOUT_EN` defined): `ejetor_pronto` held 0, `valor_troco`=10, slot2=1 → `ejetar` drops after 15 cycles; `erro`=1, `falta`=10.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin denominations, wallet geometry
// and the change-dispenser FSM states.
package vm_pkg;

  localparam int unsigned N_SLOTS   = 6;
  localparam int unsigned LARG_CONT = 4;

  localparam logic [7:0] DENOM [N_SLOTS] = '{8'd1, 8'd5, 8'd10, 8'd25, 8'd50, 8'd100};

  typedef enum logic [1:0] {
    OCIOSO,
    BUSCA,
    EJETA,
    FIM
  } estado_t;

  typedef logic [N_SLOTS-1:0][LARG_CONT-1:0] contagens_t;

endpackage

// File: rtl/despachante_troco_if.sv
// Change-dispenser bus: start/amount/wallet from vm, coin ejector handshake,
// and completion status. master = dispenser side, slave = environment side.
interface despachante_troco_if;
  import vm_pkg::*;

  logic                           iniciar;
  logic [7:0]                     valor_troco;
  logic [N_SLOTS*LARG_CONT-1:0]   moedas_carteira;
  logic                           ejetor_pronto;
  logic                           ejetar;
  logic [2:0]                     moeda_sel;
  logic                           ocupado;
  logic                           concluido;
  logic                           erro;
  logic [7:0]                     falta;

  modport master (
    input  iniciar, valor_troco, moedas_carteira, ejetor_pronto,
    output ejetar, moeda_sel, ocupado, concluido, erro, falta
  );

  modport slave (
    output iniciar, valor_troco, moedas_carteira, ejetor_pronto,
    input  ejetar, moeda_sel, ocupado, concluido, erro, falta
  );

endinterface

// File: rtl/despachante_troco_seletor_moeda.sv
// Combinational greedy picker: highest slot whose denomination fits the
// remaining amount and still has coins available.
module seletor_moeda
  import vm_pkg::*;
(
  input  logic [7:0]  resto,
  input  contagens_t  cont,
  output logic        valido,
  output logic [2:0]  slot
);

  // Ascending scan; the last qualifying slot (highest denomination) wins.
  always_comb begin
    valido = 1'b0;
    slot   = '0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      if ((DENOM[k] <= resto) && (cont[k] != '0)) begin
        valido = 1'b1;
        slot   = 3'(k);
      end
    end
  end

endmodule

// File: rtl/despachante_troco.sv
// Change-dispensing controller: latches amount and wallet snapshot, then
// ejects coins greedily one at a time. EJETOR_TIMEOUT_EN adds an ejector watchdog.
module despachante_troco
  import vm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  despachante_troco_if.master  bus
);

  if ((TIMEOUT_CICLOS < 1) || (TIMEOUT_CICLOS > 16)) begin : g_timeout_invalido
    $error("TIMEOUT_CICLOS must fit the 4-bit watchdog (1..16)");
  end

  estado_t     estado, estado_prox;
  logic [7:0]  resto, resto_prox;
  contagens_t  cont, cont_prox;
  logic [2:0]  sel_q, sel_prox;
  logic        erro_prox;
  logic        valido;
  logic [2:0]  slot_esc;
  logic        ejetar_q, ocupado_q, concluido_q, erro_q;
  logic [7:0]  falta_q;
`ifdef EJETOR_TIMEOUT_EN
  logic [3:0]  wd, wd_prox;
`endif

  seletor_moeda u_seletor (
    .resto  (resto),
    .cont   (cont),
    .valido (valido),
    .slot   (slot_esc)
  );

  always_comb begin
    estado_prox = estado;
    resto_prox  = resto;
    cont_prox   = cont;
    sel_prox    = sel_q;
    erro_prox   = 1'b0;
`ifdef EJETOR_TIMEOUT_EN
    wd_prox     = wd;
`endif
    unique case (estado)
      OCIOSO: begin
        if (bus.iniciar) begin
          estado_prox = BUSCA;
          resto_prox  = bus.valor_troco;
          cont_prox   = bus.moedas_carteira;
        end
      end
      BUSCA: begin
        if (resto == '0) begin
          estado_prox = FIM;
        end else if (valido) begin
          estado_prox = EJETA;
          sel_prox    = slot_esc;
`ifdef EJETOR_TIMEOUT_EN
          wd_prox     = '0;
`endif
        end else begin
          estado_prox = FIM;
          erro_prox   = 1'b1;
        end
      end
      EJETA: begin
        if (bus.ejetor_pronto) begin
          resto_prox      = resto - DENOM[sel_q];
          cont_prox[sel_q] = cont[sel_q] - 4'd1;
          estado_prox     = BUSCA;
        end
`ifdef EJETOR_TIMEOUT_EN
        // Timeout keeps resto untouched, so falta still counts the refused coin.
        else if (wd == 4'(TIMEOUT_CICLOS - 1)) begin
          estado_prox = FIM;
          erro_prox   = 1'b1;
        end else begin
          wd_prox = wd + 4'd1;
        end
`endif
      end
      FIM:     estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= OCIOSO;
      resto       <= '0;
      cont        <= '0;
      sel_q       <= '0;
      ejetar_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
      falta_q     <= '0;
`ifdef EJETOR_TIMEOUT_EN
      wd          <= '0;
`endif
    end else begin
      estado      <= estado_prox;
      resto       <= resto_prox;
      cont        <= cont_prox;
      sel_q       <= sel_prox;
      ejetar_q    <= (estado_prox == EJETA);
      ocupado_q   <= (estado_prox != OCIOSO);
      concluido_q <= (estado_prox == FIM);
      erro_q      <= erro_prox;
      falta_q     <= (estado_prox == FIM) ? resto : '0;
`ifdef EJETOR_TIMEOUT_EN
      wd          <= wd_prox;
`endif
    end
  end

  assign bus.ejetar    = ejetar_q;
  assign bus.moeda_sel = sel_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.concluido = concluido_q;
  assign bus.erro      = erro_q;
  assign bus.falta     = falta_q;

endmodule
